cb_config_loader: RTL and testbench

CB_CONFIG_LOADER -- requirements
Module: cb_config_loader

---
 rtl/cb_cfg_pkg.sv | 17 +
 rtl/cb_cfg_checksum.sv | 23 ++
 rtl/cb_config_loader.sv | 140 ++++++++++++++
 tb/tb_cb_config_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the connection-block configuration loader.
package cb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } cb_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cb_cfg_checksum.sv
// Running XOR of the data words of one configuration load.
module cb_cfg_checksum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accumulate) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/cb_config_loader.sv
// Streams WORD_W-bit words into a shadow register and commits them to cfg_out atomically.
// Optional trailing checksum word is enabled with the macro CB_CFG_CHECKSUM_EN.
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int CFG_W  = 256,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int NWORDS = ceil_div(CFG_W, WORD_W);
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in LOAD/CHECK and drops combinationally on abort.
  cb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] shadow_q;
  logic             hs;
  logic             begin_load;
  logic             last_word;

  assign in_ready   = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !abort;
  assign hs         = in_valid && in_ready;
  assign begin_load = ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERROR)) && start && !abort;
  assign last_word  = (cnt_q == LAST_IDX);

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_COMMIT);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

`ifdef CB_CFG_CHECKSUM_EN
  logic [WORD_W-1:0] sum_acc;
  logic              sum_ok;
  logic              err_q;

  cb_cfg_checksum #(.WIDTH(WORD_W)) u_checksum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (begin_load),
    .accumulate ((state_q == ST_LOAD) && hs),
    .data       (in_data),
    .acc        (sum_acc)
  );

  assign sum_ok = (in_data == sum_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (begin_load) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_CHECK) && hs && !sum_ok) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: if (begin_load) state_d = ST_LOAD;
      ST_DONE:           state_d = begin_load ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hs && last_word) begin
`ifdef CB_CFG_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_COMMIT;
`endif
        end
      end
`ifdef CB_CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hs) begin
          state_d = sum_ok ? ST_COMMIT : ST_ERROR;
        end
      end
`endif
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (begin_load) begin
        cnt_q <= '0;
      end else if ((state_q == ST_LOAD) && hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Only bits below CFG_W exist, so the excess of the last word falls away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if ((state_q == ST_LOAD) && hs) begin
      for (int i = 0; i < CFG_W; i++) begin
        if ((i / WORD_W) == int'(cnt_q)) shadow_q[i] <= in_data[i % WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out <= '0;
    end else if (state_q == ST_COMMIT) begin
      cfg_out <= shadow_q;
    end
  end

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader with a 20-bit vector of 8-bit words.
module tb_cb_config_loader;
  import cb_cfg_pkg::*;

  localparam int CFG_W  = 20;
  localparam int WORD_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic [CFG_W-1:0]  cfg_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [CFG_W-1:0] exp_q[$];
  logic [CFG_W-1:0] cur_cfg;

  cb_config_loader #(.CFG_W(CFG_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_state", 32'(dbg_state), 32'(ST_LOAD));
  endtask

  // Optional idle gap with garbage data on an invalid cycle, then one handshake.
  task automatic send_word(input logic [WORD_W-1:0] d, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hFF;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    #1;
    n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("rdy_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input bit gap, input logic [CFG_W-1:0] exp);
    int n;
    exp_q.push_back(exp);
    pulse_start();
    send_word(w0, gap);
    send_word(w1, gap);
    send_word(w2, gap);
`ifdef CB_CFG_CHECKSUM_EN
    send_word(w0 ^ w1 ^ w2, gap);
`endif
    check("commit_state", 32'(dbg_state), 32'(ST_COMMIT));
    check("no_partial", 32'(cfg_out), 32'(cur_cfg));
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("done_lat", 32'(n), 32'd1);
    check("cfg_out", 32'(cfg_out), 32'(exp_q.pop_front()));
    check("err_clear", 32'(err), 32'd0);
    cur_cfg = exp;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cur_cfg  = '0;
    repeat (2) @(negedge clk);
    check("rst_cfg", 32'(cfg_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // basic load, top nibble of last word dropped
    run_load(8'hA5, 8'h3C, 8'hF7, 1'b0, 20'h73CA5);
    run_load(8'h11, 8'h22, 8'h33, 1'b0, 20'h32211);
    // in_valid toggling with garbage on idle cycles
    run_load(8'hA5, 8'h3C, 8'hF7, 1'b1, 20'h73CA5);

`ifdef CB_CFG_CHECKSUM_EN
    pulse_start();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    send_word(8'hF7, 1'b0);
    send_word(8'h00, 1'b0);
    check("bad_sum_state", 32'(dbg_state), 32'(ST_ERROR));
    check("bad_sum_err", 32'(err), 32'd1);
    check("bad_sum_cfg", 32'(cfg_out), 32'(cur_cfg));
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    pulse_start();
    check("start_clr_err", 32'(err), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    // abort after two words
    pulse_start();
    send_word(8'h11, 1'b0);
    start = 1'b1;
    send_word(8'h22, 1'b0);
    start = 1'b0;
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    #1;
    check("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cfg", 32'(cfg_out), 32'(cur_cfg));
    run_load(8'h55, 8'h66, 8'h77, 1'b0, 20'h76655);

    // reset during LOAD
    pulse_start();
    send_word(8'hAA, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cfg", 32'(cfg_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cur_cfg = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_load(8'h01, 8'h02, 8'h03, 1'b0, 20'h30201);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("sa_state", 32'(dbg_state), 32'(ST_IDLE));
    check("sa_busy", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
